// File: rtl/vertex_post_processor.sv
// Clip-space to screen-space vertex transform: reciprocal of w, clip test, viewport mapping.
// Latency: accept to o_vertex_valid is 2*FRACBITS+3 cycles (29 at defaults), or 1 cycle when w<=0.
// Backpressure: handles one vertex at a time; o_ready stays low until the output handshake completes.
module vertex_post_processor #(
  parameter int DATAWIDTH     = 24,
  parameter int FRACBITS      = 13,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240,
  parameter int COORDWIDTH    = 12
) (
  input  logic                          clk,
  input  logic                          rstn,
  // packed as {w, z, y, x}, x in the least significant word
  input  logic [4*DATAWIDTH-1:0]        i_vertex,
  input  logic                          i_vertex_valid,
  output logic                          o_ready,
  input  logic                          i_finished,
  output logic signed [COORDWIDTH-1:0]  o_vertex_x,
  output logic signed [COORDWIDTH-1:0]  o_vertex_y,
  output logic signed [DATAWIDTH-1:0]   o_vertex_z,
  output logic                          o_clipped,
  output logic                          o_vertex_valid,
  input  logic                          i_ready,
  output logic [15:0]                   o_vertex_count,
  output logic                          o_finished
);

  localparam int DW       = DATAWIDTH;
  localparam int DW1      = DATAWIDTH + 1;
  localparam int PW       = 2 * DATAWIDTH;
  localparam int VW       = DATAWIDTH + 16;
  localparam int QW       = 2 * FRACBITS + 1;
  localparam int CW       = $clog2(QW);
  localparam int ONE      = 1 << FRACBITS;
  localparam int SW_HALF  = SCREEN_WIDTH / 2;
  localparam int SH_HALF  = SCREEN_HEIGHT / 2;

  localparam logic [QW-1:0]        Q_MAX    = QW'((2 ** (DW - 1)) - 1);
  localparam logic [CW-1:0]        DIV_LAST = CW'(QW - 1);
  localparam logic signed [VW-1:0] C_MAX    = VW'((2 ** (COORDWIDTH - 1)) - 1);
  localparam logic signed [VW-1:0] C_MIN    = -C_MAX - VW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIVIDE,
    S_MUL,
    S_VIEWPORT,
    S_OUTPUT,
    S_FINISH
  } state_t;

  state_t                        r_state;
  logic signed [DW-1:0]          r_x, r_y, r_z;
  logic        [DW-1:0]          r_w;
  logic                          r_clip;
  logic        [DW-1:0]          r_rem;
  logic        [QW-1:0]          r_num;
  logic        [QW-1:0]          r_quot;
  logic        [CW-1:0]          r_div_cnt;
  logic signed [DW-1:0]          r_ndc_x, r_ndc_y, r_ndc_z;
  logic signed [COORDWIDTH-1:0]  r_sx, r_sy;
  logic signed [DW-1:0]          r_sz;
  logic                          r_clipped;
  logic                          r_valid;
  logic                          r_ready;
  logic [15:0]                   r_count;
  logic                          r_finished;
  logic                          r_pend;

  // incoming vertex fields and the clip-volume test
  logic signed [DW-1:0]  w_in_x, w_in_y, w_in_z, w_in_w;
  logic signed [DW1-1:0] w_abs_x, w_abs_y, w_abs_z, w_ext_w;
  logic                  w_clip_in;
  logic                  w_accept;

  assign w_in_x   = $signed(i_vertex[0*DW +: DW]);
  assign w_in_y   = $signed(i_vertex[1*DW +: DW]);
  assign w_in_z   = $signed(i_vertex[2*DW +: DW]);
  assign w_in_w   = $signed(i_vertex[3*DW +: DW]);
  // one extra bit so that |most-negative| does not overflow
  assign w_abs_x  = w_in_x[DW-1] ? -DW1'(w_in_x) : DW1'(w_in_x);
  assign w_abs_y  = w_in_y[DW-1] ? -DW1'(w_in_y) : DW1'(w_in_y);
  assign w_abs_z  = w_in_z[DW-1] ? -DW1'(w_in_z) : DW1'(w_in_z);
  assign w_ext_w  = DW1'(w_in_w);
  assign w_clip_in = (w_in_w <= 0) || (w_abs_x > w_ext_w) ||
                     (w_abs_y > w_ext_w) || (w_abs_z > w_ext_w);
  assign w_accept = i_vertex_valid && r_ready;

  // restoring divider step: bring down the next dividend bit, subtract w if it fits
  logic [DW1-1:0] w_rem_sh, w_rem_sub;
  logic           w_ge;

  assign w_rem_sh  = {r_rem, r_num[QW-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_w};
  assign w_rem_sub = w_rem_sh - {1'b0, r_w};

  // reciprocal saturated into the signed word, then the three perspective products
  logic signed [DW-1:0] w_inv_w;
  logic signed [PW-1:0] w_px, w_py, w_pz;

  assign w_inv_w = (r_quot > Q_MAX) ? $signed(DW'(Q_MAX)) : $signed(DW'(r_quot));
  assign w_px    = r_x * w_inv_w;
  assign w_py    = r_y * w_inv_w;
  assign w_pz    = r_z * w_inv_w;

  // viewport mapping, y flipped so NDC +1 lands on the top row
  logic signed [VW-1:0] w_vx, w_vy;

  assign w_vx = ((VW'(r_ndc_x) + VW'(ONE)) * VW'(SW_HALF)) >>> FRACBITS;
  assign w_vy = ((VW'(ONE) - VW'(r_ndc_y)) * VW'(SH_HALF)) >>> FRACBITS;

  function automatic logic signed [COORDWIDTH-1:0] sat_coord(input logic signed [VW-1:0] v);
    if (v > C_MAX)      sat_coord = COORDWIDTH'(C_MAX);
    else if (v < C_MIN) sat_coord = COORDWIDTH'(C_MIN);
    else                sat_coord = COORDWIDTH'(v);
  endfunction

  // main sequencer: accept, divide, multiply, viewport, output handshake, finish pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_w        <= '0;
      r_clip     <= 1'b0;
      r_rem      <= '0;
      r_num      <= '0;
      r_quot     <= '0;
      r_div_cnt  <= '0;
      r_ndc_x    <= '0;
      r_ndc_y    <= '0;
      r_ndc_z    <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_sz       <= '0;
      r_clipped  <= 1'b0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b0;
      r_count    <= '0;
      r_finished <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      if (i_finished) r_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x       <= w_in_x;
            r_y       <= w_in_y;
            r_z       <= w_in_z;
            r_w       <= w_in_w;
            r_clip    <= w_clip_in;
            r_ready   <= 1'b0;
            r_rem     <= '0;
            r_num     <= QW'(1) << (QW - 1);
            r_quot    <= '0;
            r_div_cnt <= '0;
            if (w_in_w <= 0) begin
              // degenerate w: skip the transform, report it as clipped
              r_sx      <= '0;
              r_sy      <= '0;
              r_sz      <= '0;
              r_clipped <= 1'b1;
              r_state   <= S_OUTPUT;
            end else begin
              r_state <= S_DIVIDE;
            end
          end else if (r_pend || i_finished) begin
            r_ready    <= 1'b0;
            r_finished <= 1'b1;
            r_state    <= S_FINISH;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_DIVIDE: begin
          r_num  <= {r_num[QW-2:0], 1'b0};
          r_quot <= {r_quot[QW-2:0], w_ge};
          r_rem  <= w_ge ? DW'(w_rem_sub) : DW'(w_rem_sh);
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_state   <= S_MUL;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_MUL: begin
          r_ndc_x <= DW'(w_px >>> FRACBITS);
          r_ndc_y <= DW'(w_py >>> FRACBITS);
          r_ndc_z <= DW'(w_pz >>> FRACBITS);
          r_state <= S_VIEWPORT;
        end
        S_VIEWPORT: begin
          r_sx      <= sat_coord(w_vx);
          r_sy      <= sat_coord(w_vy);
          r_sz      <= r_ndc_z;
          r_clipped <= r_clip;
          r_valid   <= 1'b1;
          r_state   <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (!r_valid) begin
            // w<=0 path arrives here with valid still low
            r_valid <= 1'b1;
          end else if (i_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + 16'd1;
            if (r_pend || i_finished) begin
              r_finished <= 1'b1;
              r_state    <= S_FINISH;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_FINISH: begin
          // a fresh finish pulse arriving right now must not be lost
          r_pend  <= i_finished;
          r_count <= '0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready        = r_ready;
  assign o_vertex_x     = r_sx;
  assign o_vertex_y     = r_sy;
  assign o_vertex_z     = r_sz;
  assign o_clipped      = r_clipped;
  assign o_vertex_valid = r_valid;
  assign o_vertex_count = r_count;
  assign o_finished     = r_finished;

endmodule

// File: tb/tb_vertex_post_processor.sv
// Directed bench for vertex_post_processor with a scoreboard of expected screen vertices.
module tb_vertex_post_processor;

  logic               clk;
  logic               rstn;
  logic [95:0]        i_vertex;
  logic               i_vertex_valid;
  logic               o_ready;
  logic               i_finished;
  logic signed [11:0] o_vertex_x;
  logic signed [11:0] o_vertex_y;
  logic signed [23:0] o_vertex_z;
  logic               o_clipped;
  logic               o_vertex_valid;
  logic               i_ready;
  logic [15:0]        o_vertex_count;
  logic               o_finished;

  vertex_post_processor dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_vertex       (i_vertex),
    .i_vertex_valid (i_vertex_valid),
    .o_ready        (o_ready),
    .i_finished     (i_finished),
    .o_vertex_x     (o_vertex_x),
    .o_vertex_y     (o_vertex_y),
    .o_vertex_z     (o_vertex_z),
    .o_clipped      (o_clipped),
    .o_vertex_valid (o_vertex_valid),
    .i_ready        (i_ready),
    .o_vertex_count (o_vertex_count),
    .o_finished     (o_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sx;
    int sy;
    int sz;
    int clip;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint sat12(input longint v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // reference transform written from the arithmetic definition
  function automatic exp_t model(input longint x, input longint y, input longint z, input longint w);
    exp_t e;
    longint inv, nx, ny, nz;
    logic signed [23:0] t;
    e.clip = ((w <= 0) || ((x < 0 ? -x : x) > w) || ((y < 0 ? -y : y) > w) ||
              ((z < 0 ? -z : z) > w)) ? 1 : 0;
    if (w <= 0) begin
      e.sx = 0; e.sy = 0; e.sz = 0; e.lat = 1;
      return e;
    end
    inv = (longint'(1) << 26) / w;
    if (inv > 8388607) inv = 8388607;
    t = 24'((x * inv) >>> 13); nx = t;
    t = 24'((y * inv) >>> 13); ny = t;
    t = 24'((z * inv) >>> 13); nz = t;
    e.sx  = int'(sat12(((nx + 8192) * 160) >>> 13));
    e.sy  = int'(sat12(((8192 - ny) * 120) >>> 13));
    e.sz  = int'(nz);
    e.lat = 29;
    return e;
  endfunction

  // drive one vertex, track it to the output, optionally stall and/or pulse i_finished
  task automatic do_vertex(input int x, input int y, input int z, input int w,
                           input int hold, input int fin_at);
    exp_t e;
    int   t;
    int   lat;
    bit   got;
    t = 0;
    while (!o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_accept", o_ready, 1);
    i_vertex       = {24'(w), 24'(z), 24'(y), 24'(x)};
    i_vertex_valid = 1'b1;
    i_finished     = (fin_at == 0);
    sb.push_back(model(x, y, z, w));
    @(posedge clk); #1;
    i_vertex_valid = 1'b0;
    i_finished     = 1'b0;
    chk("ready_drop_on_accept", o_ready, 0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      i_finished = (fin_at > 0 && lat == fin_at);
      got = o_vertex_valid;
    end
    i_finished = 1'b0;
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("sx", o_vertex_x, e.sx);
    chk("sy", o_vertex_y, e.sy);
    chk("sz", o_vertex_z, e.sz);
    chk("clipped", o_clipped, e.clip);
    for (int i = 0; i < hold; i++) begin
      i_vertex_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", o_vertex_valid, 1);
      chk("hold_sx", o_vertex_x, e.sx);
      chk("hold_sy", o_vertex_y, e.sy);
      chk("hold_ready", o_ready, 0);
    end
    i_vertex_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    chk("valid_after_handshake", o_vertex_valid, 0);
    chk("count_after_handshake", o_vertex_count, exp_cnt);
  endtask

  initial begin
    rstn           = 1'b0;
    i_vertex       = '0;
    i_vertex_valid = 1'b0;
    i_finished     = 1'b0;
    i_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", o_vertex_x, 0);
    chk("rst_y", o_vertex_y, 0);
    chk("rst_z", o_vertex_z, 0);
    chk("rst_clipped", o_clipped, 0);
    chk("rst_valid", o_vertex_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_count", o_vertex_count, 0);
    chk("rst_finished", o_finished, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", o_ready, 1);

    // centre, off-centre, second w, clipped, degenerate w
    do_vertex(0, 0, 0, 8192, 0, -1);
    do_vertex(4096, -4096, 2048, 8192, 0, -1);
    do_vertex(8192, 8192, 0, 16384, 0, -1);
    do_vertex(16384, 0, 0, 8192, 0, -1);
    do_vertex(0, 0, 0, 0, 0, -1);
    do_vertex(100, 100, 100, -5, 0, -1);
    // coordinate saturation and reciprocal saturation
    do_vertex(3000, 3000, 0, 100, 0, -1);
    do_vertex(0, 0, 5, 1, 0, -1);
    // downstream stall with an input trying to sneak in
    do_vertex(-4096, 2048, -1000, 8192, 10, -1);

    // finish while idle clears the count
    @(negedge clk);
    i_finished = 1'b1;
    @(posedge clk); #1;
    i_finished = 1'b0;
    chk("idle_fin_pulse", o_finished, 1);
    chk("idle_fin_ready", o_ready, 0);
    @(posedge clk); #1;
    exp_cnt = 0;
    chk("idle_fin_end", o_finished, 0);
    chk("idle_fin_count", o_vertex_count, exp_cnt);
    chk("idle_fin_ready_back", o_ready, 1);

    // three vertices, finish pulsed during the third divide
    do_vertex(1000, 2000, 3000, 8192, 0, -1);
    do_vertex(-8192, 8192, 8192, 8192, 0, -1);
    do_vertex(500, -700, 900, 4096, 0, 6);
    chk("fin_pulse", o_finished, 1);
    chk("fin_count_before", o_vertex_count, 3);
    @(posedge clk); #1;
    exp_cnt = 0;
    chk("fin_pulse_end", o_finished, 0);
    chk("fin_count_after", o_vertex_count, exp_cnt);

    // finish coinciding with an accept: vertex first, then the pulse
    do_vertex(2048, 2048, 2048, 8192, 0, 0);
    chk("coinc_fin_pulse", o_finished, 1);
    @(posedge clk); #1;
    exp_cnt = 0;
    chk("coinc_fin_count", o_vertex_count, exp_cnt);

    // reset in the middle of a divide
    @(negedge clk);
    i_vertex       = {24'd8192, 24'd4096, 24'd4096, 24'd4096};
    i_vertex_valid = 1'b1;
    @(posedge clk); #1;
    i_vertex_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", o_vertex_valid, 0);
    chk("midrst_ready", o_ready, 0);
    chk("midrst_x", o_vertex_x, 0);
    chk("midrst_clipped", o_clipped, 0);
    repeat (3) @(posedge clk); #1;
    chk("midrst_no_output", o_vertex_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0;
    do_vertex(-2048, -2048, 1024, 8192, 0, -1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vertex_post_processor.md
Name: vertex_post_processor

Overview:
- Consumes clip-space vertices from the vertex shader output stream (x, y, z, w in signed fixed point) and produces screen-space vertices.
- Per vertex: perspective divide via an iterative reciprocal of w, clip-volume test, then viewport transform to integer pixel coordinates.
- Sits between the vertex shader and the primitive assembler/rasterizer. It is the receiving end of the shader's valid/ready/finished stream.

Parameters:
- DATAWIDTH, 24, fixed-point word width (signed).
- FRACBITS, 13, fractional bits; ONE = 1<<FRACBITS.
- SCREEN_WIDTH, 320, pixels.
- SCREEN_HEIGHT, 240, pixels.
- COORDWIDTH, 12, signed width of the output pixel coordinates.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- i_vertex  in  4x DATAWIDTH signed  clip-space x, y, z, w.
- i_vertex_valid  in  1  input vertex valid.
- o_ready  out  1  ready to accept a vertex; drives the shader's i_ready.
- i_finished  in  1  one-cycle pulse from the shader: the last vertex has been handed over.
- o_vertex_x  out  COORDWIDTH signed  screen x.
- o_vertex_y  out  COORDWIDTH signed  screen y.
- o_vertex_z  out  DATAWIDTH signed  NDC depth.
- o_clipped  out  1  vertex lies outside the clip volume.
- o_vertex_valid  out  1  output valid.
- i_ready  in  1  downstream ready.
- o_vertex_count  out  16  number of vertices output since the last o_finished.
- o_finished  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset: all outputs 0, including o_ready. State IDLE; divider counter 0; pending_finish 0.
- Reset has priority at any point, including mid-divide or mid-output; the in-flight vertex is discarded.
- Input accept occurs on an edge where i_vertex_valid && o_ready. At that edge:
  - The vertex is registered.
  - o_ready goes to 0.
  - clip = (w<=0) || |x|>w || |y|>w || |z|>w is registered.
- o_ready is 1 only in IDLE and not while o_finished is pulsing. It is a registered output.
- States:
  - IDLE: wait for accept. If w<=0 go to OUTPUT with x/y/z outputs 0 and o_clipped=1; o_vertex_valid rises on the following edge. Otherwise go to DIVIDE.
  - DIVIDE: restoring division inv_w = (1<<(2*FRACBITS)) / w, one quotient bit per cycle, DIV_CYCLES = 2*FRACBITS+1 cycles. The quotient saturates to the DATAWIDTH signed max. Then go to MUL.
  - MUL: 1 cycle. ndc_k = (k*inv_w)>>>FRACBITS for k in {x,y,z}, full 2*DATAWIDTH product, truncated to DATAWIDTH.
  - VIEWPORT: 1 cycle.
    - sx = ((ndc_x+ONE)*(SCREEN_WIDTH/2))>>>FRACBITS
    - sy = ((ONE-ndc_y)*(SCREEN_HEIGHT/2))>>>FRACBITS (y flipped)
    - sz = ndc_z
    - sx and sy saturate to the COORDWIDTH signed range.
    - Outputs are registered and o_vertex_valid=1 on exit. Go to OUTPUT.
  - OUTPUT: outputs held stable while o_vertex_valid && !i_ready. On i_ready: o_vertex_valid=0, o_vertex_count++. Then:
    - If pending_finish: go to FINISH.
    - Otherwise: go to IDLE.
  - FINISH: o_finished=1 for exactly one cycle, o_vertex_count cleared, pending_finish cleared, then IDLE.
- Latency, accept edge to o_vertex_valid high: DIV_CYCLES+2 cycles for the normal path (29 at defaults); 1 cycle for w<=0.
- Throughput: one vertex per latency plus the output handshake. There is no overlap between vertices.
- i_finished handling:
  - Latched into pending_finish in any state.
  - If it arrives in IDLE with no vertex in flight, go to FINISH on the next edge.
  - If i_finished coincides with an accept, the vertex is processed first, then FINISH.
- Clipped vertices with w>0 are still fully transformed and output with o_clipped=1. The saturation rules apply to them.
- The count wraps at 2^16.

Test Plan:
- (0,0,0,8192) -> after 29 cycles: sx=160, sy=120, sz=0, o_clipped=0; o_vertex_count=1 after the handshake.
- (4096,-4096,2048,8192) -> sx=240, sy=180, sz=2048, clipped=0. Then (8192,8192,0,16384) -> inv_w=4096, sx=240, sy=60, sz=0.
- (16384,0,0,8192) -> o_clipped=1, sx=480 saturates to 480 (within 12-bit), sy=120. (0,0,0,0) -> valid 1 cycle after accept, all outputs 0, clipped=1.
- Hold i_ready=0 for 10 cycles during OUTPUT -> outputs stable, o_ready=0, no second accept. Release -> single handshake, count increments by 1.
- Three vertices, with i_finished pulsed during DIVIDE of the third -> o_finished pulses one cycle after the third output handshake; o_vertex_count reads 3 before the pulse and 0 after. i_finished while IDLE -> o_finished 1 cycle later.
- Assert rstn=0 mid-DIVIDE -> next cycle all outputs 0, state IDLE. After release, a fresh vertex produces correct results with no stale data.
